// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the bus slave register bank write path.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } wr_state_e;

  localparam int unsigned WR_CNT_W     = 16;
  localparam int unsigned DEF_NUM_REGS = 23;
  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 32;

  // Saturating increment for the write counter
  function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] v);
    return (&v) ? v : v + WR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder; the output is all zeros when en is low.
module onehot_decoder #(
  parameter int unsigned N     = 23,
  parameter int unsigned IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < N; i++) begin
      onehot_c[i] = en && (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Sequenced register write controller: range check, one-hot strobe, ack, write count.
// Optional out-of-range reporting (err/err_addr/err_clr) is built when WR_ERR_EN is defined.
module reg_write_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_wdata,
`ifdef WR_ERR_EN
  input  logic                err_clr,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
`endif
  output logic                s_ack,
  output logic [NUM_REGS-1:0] to_reg,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [WR_CNT_W-1:0] wr_cnt
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_WRITE = 2'(WRITE);
  localparam logic [1:0] S_ACK   = 2'(ACK);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Compare width wide enough for both the address offset and NUM_REGS (<= 64)
  localparam int unsigned CMP_W = (ADDR_W > 8) ? ADDR_W : 8;

  logic [1:0]          state, state_nxt;
  logic                hit, hit_nxt;
  logic                ack_nxt;
  logic [NUM_REGS-1:0] to_reg_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [WR_CNT_W-1:0] cnt_nxt;

  logic                req_c;
  logic [ADDR_W-1:0]   idx_c;
  logic                in_range_c;
  logic                dec_en_c;
  logic [NUM_REGS-1:0] dec_c;

`ifdef WR_ERR_EN
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
  logic                err_nxt;
  logic [ADDR_W-1:0]   err_addr_nxt;
`endif

  assign req_c      = s_sel & s_wr;
  assign idx_c      = s_addr - BASE_ADDR;
  assign in_range_c = (s_addr >= BASE_ADDR) && (CMP_W'(idx_c) < CMP_W'(NUM_REGS));
  assign dec_en_c   = (state == S_IDLE) && req_c && in_range_c;

  onehot_decoder #(
    .N     (NUM_REGS),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx      (IDX_W'(idx_c)),
    .en       (dec_en_c),
    .onehot_c (dec_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    hit_nxt    = hit;
    ack_nxt    = 1'b0;
    to_reg_nxt = '0;
    wdata_nxt  = reg_wdata;
    cnt_nxt    = wr_cnt;
`ifdef WR_ERR_EN
    lat_addr_nxt = lat_addr;
    err_nxt      = err;
    err_addr_nxt = err_addr;
`endif
    case (state)
      S_IDLE: begin
        if (req_c) begin
          state_nxt  = S_WRITE;
          hit_nxt    = in_range_c;
          to_reg_nxt = dec_c;
          wdata_nxt  = s_wdata;
`ifdef WR_ERR_EN
          lat_addr_nxt = s_addr;
`endif
        end
      end
      S_WRITE: begin
        state_nxt = S_ACK;
        ack_nxt   = 1'b1;
        if (hit) begin
          cnt_nxt = sat_inc(wr_cnt);
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
`ifdef WR_ERR_EN
    // A set in the same cycle as a clear takes priority and keeps the first address
    if ((state == S_WRITE) && !hit) begin
      err_nxt = 1'b1;
      if (!err) begin
        err_addr_nxt = lat_addr;
      end
    end else if (err_clr) begin
      err_nxt      = 1'b0;
      err_addr_nxt = '0;
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hit       <= 1'b0;
      s_ack     <= 1'b0;
      to_reg    <= '0;
      reg_wdata <= '0;
      wr_cnt    <= '0;
`ifdef WR_ERR_EN
      lat_addr  <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      hit       <= hit_nxt;
      s_ack     <= ack_nxt;
      to_reg    <= to_reg_nxt;
      reg_wdata <= wdata_nxt;
      wr_cnt    <= cnt_nxt;
`ifdef WR_ERR_EN
      lat_addr  <= lat_addr_nxt;
      err       <= err_nxt;
      err_addr  <= err_addr_nxt;
`endif
    end
  end

endmodule
